conv_stream_engine: RTL and testbench

//  Parametrised streaming 1-D convolution engine; next generation of convolution_layer.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_stream_engine_if.sv | 34 +++
 rtl/conv_mac_tree.sv | 34 +++
 rtl/conv_stream_engine.sv | 157 +++++++++++++++
 tb/tb_conv_stream_engine.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the streaming 1-D convolution engine.
package conv_pkg;

  localparam int MAX_W      = 64;
  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int TAPS_DEF   = 9;
  localparam int OUT_W_DEF  = 32;

  typedef logic signed [MAX_W-1:0]      wide_t;
  typedef logic signed [COEF_W_DEF-1:0] coef_arr_t [TAPS_DEF];

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic wide_t sat_max(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic wide_t sat_min(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  function automatic logic sat_hit(input wide_t v, input int out_w);
    return (v > sat_max(out_w)) || (v < sat_min(out_w));
  endfunction

  function automatic wide_t saturate(input wide_t v, input int out_w);
    if (v > sat_max(out_w)) begin
      return sat_max(out_w);
    end else if (v < sat_min(out_w)) begin
      return sat_min(out_w);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/conv_stream_engine_if.sv
// Configuration, sample-in and result-out bundle of the convolution engine.
interface conv_stream_engine_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 9,
  parameter int OUT_W  = 32
);
  localparam int ADDR_W = $clog2(TAPS);

  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic signed [COEF_W-1:0] cfg_wdata;
  logic                     cfg_err;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_last;
  logic                     busy;
  logic                     sat_flag;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, in_last, out_ready,
    input  cfg_err, in_ready, out_valid, out_data, out_last, busy, sat_flag
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, in_last, out_ready,
    output cfg_err, in_ready, out_valid, out_data, out_last, busy, sat_flag
  );
endinterface

// File: rtl/conv_mac_tree.sv
// Stateless TAPS-wide multiply followed by a balanced pairwise adder tree.
module conv_mac_tree #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 9,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic signed [DATA_W-1:0] x [TAPS],
  input  logic signed [COEF_W-1:0] w [TAPS],
  output logic signed [ACC_W-1:0]  sum
);
  localparam int LVLS   = $clog2(TAPS);
  localparam int LEAVES = 1 << LVLS;

  logic signed [ACC_W-1:0] lvl_s [LVLS+1][LEAVES];

  // Products fill the leaves (missing leaves are zero); each level halves the live nodes.
  always_comb begin
    for (int l = 0; l <= LVLS; l++) begin
      for (int i = 0; i < LEAVES; i++) begin
        lvl_s[l][i] = {ACC_W{1'b0}};
      end
    end
    for (int i = 0; i < TAPS; i++) begin
      lvl_s[0][i] = ACC_W'(x[i]) * ACC_W'(w[i]);
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < (LEAVES >> (l + 1)); i++) begin
        lvl_s[l+1][i] = lvl_s[l][2*i] + lvl_s[l][2*i+1];
      end
    end
    sum = lvl_s[LVLS][0];
  end
endmodule

// File: rtl/conv_stream_engine.sv
// Streaming 1-D convolution: sample window, coefficient bank, S1 snapshot and
// saturating S2 output register with valid/ready on both sides.
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 9,
  parameter int ACC_W  = acc_width(DATA_W, COEF_W, TAPS),
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input logic clk,
  input logic reset,
  conv_stream_engine_if.slave bus
);
  localparam int ADDR_W = $clog2(TAPS);
  localparam int CNT_W  = $clog2(TAPS + 1);
  localparam logic [CNT_W:0]  TAPS_CNT  = (CNT_W + 1)'(TAPS);
  localparam logic [ADDR_W:0] TAPS_ADDR = (ADDR_W + 1)'(TAPS);

  typedef logic signed [DATA_W-1:0] win_t  [TAPS];
  typedef logic signed [COEF_W-1:0] coef_t [TAPS];

  win_t                    window_r;
  win_t                    s1_x_r;
  win_t                    window_shift_s;
  coef_t                   coef_r;
  logic [CNT_W-1:0]        fill_cnt_r;
  logic [CNT_W-1:0]        fill_next_s;
  logic [CNT_W:0]          fill_inc_s;
  logic                    s1_v_r;
  logic                    s1_last_r;
  logic                    out_valid_r;
  logic                    out_last_r;
  logic signed [OUT_W-1:0] out_data_r;
  logic                    sat_flag_r;
  logic                    cfg_err_r;

  logic                    in_ready_s;
  logic                    accept_s;
  logic                    emit_s;
  logic                    s2_load_s;
  logic                    busy_s;
  logic                    cfg_ok_s;
  logic                    cfg_rej_s;
  logic signed [ACC_W-1:0] sum_s;
  wide_t                   shifted_s;
  wide_t                   sat_val_s;
  logic                    sat_hit_s;
  logic signed [OUT_W-1:0] out_next_s;

  // Handshake, fill accounting and coefficient-write arbitration for this cycle.
  always_comb begin
    in_ready_s = reset & (~s1_v_r | ~out_valid_r | bus.out_ready);
    accept_s   = bus.in_valid & in_ready_s;
    s2_load_s  = s1_v_r & (~out_valid_r | bus.out_ready);
    busy_s     = (fill_cnt_r != {CNT_W{1'b0}}) | s1_v_r | out_valid_r;
    fill_inc_s = {1'b0, fill_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    if (fill_inc_s >= TAPS_CNT) begin
      fill_next_s = TAPS_CNT[CNT_W-1:0];
    end else begin
      fill_next_s = fill_inc_s[CNT_W-1:0];
    end
    emit_s    = accept_s & ((fill_inc_s >= TAPS_CNT) | bus.in_last);
    cfg_ok_s  = bus.cfg_we & ({1'b0, bus.cfg_addr} < TAPS_ADDR) & ~busy_s & ~accept_s;
    cfg_rej_s = bus.cfg_we & ~cfg_ok_s;
  end

  // Window as it will look after accepting the presented sample.
  always_comb begin
    window_shift_s[0] = bus.in_data;
    for (int i = 1; i < TAPS; i++) begin
      window_shift_s[i] = window_r[i-1];
    end
  end

  conv_mac_tree #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .ACC_W  (ACC_W)
  ) u_mac (
    .x   (s1_x_r),
    .w   (coef_r),
    .sum (sum_s)
  );

  // Arithmetic shift in the wide domain, then clamp to the output range.
  always_comb begin
    shifted_s  = wide_t'(sum_s) >>> SHIFT;
    sat_hit_s  = sat_hit(shifted_s, OUT_W);
    sat_val_s  = saturate(shifted_s, OUT_W);
    out_next_s = sat_val_s[OUT_W-1:0];
  end

  // Window, S1 snapshot, S2 output register, sticky flags and coefficient bank.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        window_r[i] <= {DATA_W{1'b0}};
        s1_x_r[i]   <= {DATA_W{1'b0}};
        coef_r[i]   <= {COEF_W{1'b0}};
      end
      fill_cnt_r  <= {CNT_W{1'b0}};
      s1_v_r      <= 1'b0;
      s1_last_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      sat_flag_r  <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      // A frame-closing sample is captured into S1 while the live window restarts empty.
      if (accept_s) begin
        if (bus.in_last) begin
          for (int i = 0; i < TAPS; i++) begin
            window_r[i] <= {DATA_W{1'b0}};
          end
          fill_cnt_r <= {CNT_W{1'b0}};
        end else begin
          window_r   <= window_shift_s;
          fill_cnt_r <= fill_next_s;
        end
      end
      if (emit_s) begin
        s1_x_r    <= window_shift_s;
        s1_last_r <= bus.in_last;
        s1_v_r    <= 1'b1;
      end else if (s2_load_s) begin
        s1_v_r <= 1'b0;
      end
      if (s2_load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= out_next_s;
        out_last_r  <= s1_last_r;
        if (sat_hit_s) begin
          sat_flag_r <= 1'b1;
        end
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      cfg_err_r <= cfg_rej_s;
      if (cfg_ok_s) begin
        coef_r[bus.cfg_addr] <= bus.cfg_wdata;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = busy_s;
  assign bus.sat_flag  = sat_flag_r;
  assign bus.cfg_err   = cfg_err_r;
endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench: a frame-level reference model predicts each result at
// accept time; an independent monitor pops and compares on every output beat.
module tb_conv_stream_engine;
  import conv_pkg::*;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 9;
  localparam int OUT_W  = 32;
  localparam int SHIFT  = 0;
  localparam int ADDR_W = $clog2(TAPS);

  typedef struct {
    longint value;
    logic   last;
    logic   sat;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  int     checks = 0;
  int     errors = 0;
  int     ready_mode = 0;  // 0 always ready, 1 stalled, 2 random
  exp_t   exp_q[$];
  longint hist_q[$];       // samples of the open frame, newest first
  coef_arr_t model_w;
  logic   model_sat = 1'b0;

  always #5 clk = ~clk;

  conv_stream_engine_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus ();

  conv_stream_engine #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: dot product of the frame's most recent samples against the taps.
  task automatic model_accept(input longint d, input logic last);
    longint acc;
    longint r;
    longint hi;
    longint lo;
    exp_t   e;
    hist_q.push_front(d);
    if (hist_q.size() > TAPS) void'(hist_q.pop_back());
    if (hist_q.size() >= TAPS || last) begin
      acc = 0;
      for (int i = 0; i < hist_q.size(); i++) acc += longint'(model_w[i]) * hist_q[i];
      r  = acc >>> SHIFT;
      hi = (longint'(1) <<< (OUT_W - 1)) - 1;
      lo = -(longint'(1) <<< (OUT_W - 1));
      e.sat   = (r > hi) || (r < lo);
      e.value = (r > hi) ? hi : ((r < lo) ? lo : r);
      e.last  = last;
      exp_q.push_back(e);
    end
    if (last) hist_q.delete();
  endtask

  task automatic send(input longint d, input logic last);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d[DATA_W-1:0];
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual in_ready 0 required 1 within 200 cycles");
    end else begin
      model_accept(d, last);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic write_coef(input int addr, input longint val, input logic expect_err);
    logic [31:0] a;
    a = 32'(addr);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a[ADDR_W-1:0];
    bus.cfg_wdata = val[COEF_W-1:0];
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    check("cfg_err_pulse", bus.cfg_err, expect_err);
    if (!expect_err) model_w[addr] = val[COEF_W-1:0];
    @(posedge clk);
    #1;
    check("cfg_err_clear", bus.cfg_err, 0);
  endtask

  task automatic load_all(input longint val);
    for (int i = 0; i < TAPS; i++) write_coef(i, val, 1'b0);
  endtask

  task automatic wait_drained(input logic need_idle);
    int n = 0;
    while ((exp_q.size() != 0 || (need_idle && bus.busy)) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 0);
    end
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_sat_flag", bus.sat_flag, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_busy", bus.busy, 0);
    hist_q.delete();
    for (int i = 0; i < TAPS; i++) model_w[i] = '0;
    reset = 1'b1;
  endtask

  // Downstream ready pattern, changed only just after a rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: every output beat is popped against the scoreboard; stalled beats must hold.
  initial begin : monitor
    logic   held_v;
    longint held_d;
    logic   held_l;
    exp_t   e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        held_v    = 1'b0;
        model_sat = 1'b0;
        exp_q.delete();
      end else begin
        if (held_v) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", bus.out_data, held_d);
          check("hold_last", bus.out_last, held_l);
        end
        held_v = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: actual %0d required no result", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            model_sat = model_sat | e.sat;
            check("out_data", bus.out_data, e.value);
            check("out_last", bus.out_last, e.last);
            check("sat_flag", bus.sat_flag, model_sat);
          end
        end else if (bus.out_valid) begin
          held_v = 1'b1;
          held_d = bus.out_data;
          held_l = bus.out_last;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [15:0] r16;
    int                 len;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // All-ones kernel, full frame: single 45 with two-cycle latency.
    load_all(1);
    for (int k = 1; k <= 9; k++) send(k, k == 9);
    @(negedge clk);
    check("latency_s1", bus.out_valid, 0);
    @(negedge clk);
    check("latency_s2", bus.out_valid, 1);
    wait_drained(1'b1);

    // Short frame zero-pads, then the fill restarts.
    send(2, 0); send(3, 0); send(4, 1);
    for (int k = 1; k <= 9; k++) send(k, k == 9);
    wait_drained(1'b1);

    // Identity on the newest tap, open stream, then a 5-cycle stall mid-stream.
    write_coef(0, 1, 1'b0);
    for (int i = 1; i < TAPS; i++) write_coef(i, 0, 1'b0);
    write_coef(12, 5, 1'b1);
    for (int k = 1; k <= 12; k++) send(k, 0);
    fork
      begin
        for (int k = 13; k <= 24; k++) send(k, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        ready_mode = 1;
        repeat (5) @(posedge clk);
        #2;
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        ready_mode = 0;
      end
    join
    wait_drained(1'b0);
    write_coef(1, 77, 1'b1);
    do_reset(1);

    // Saturation, then a clean frame: the flag must stay set.
    load_all(32767);
    for (int k = 1; k <= 9; k++) send(32767, k == 9);
    wait_drained(1'b1);
    send(1, 1);
    wait_drained(1'b1);
    check("sat_sticky", bus.sat_flag, 1);
    for (int k = 1; k <= 9; k++) send(-32768, k == 9);
    wait_drained(1'b1);
    do_reset(1);

    // Write racing a sample accept is dropped; busy write is dropped.
    load_all(1);
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_wdata = 16'sd55;
    send(7, 1);
    bus.cfg_we = 1'b0;
    check("cfg_err_accept", bus.cfg_err, 1);
    send(1, 0); send(2, 0);
    write_coef(1, 99, 1'b1);
    send(3, 1);
    wait_drained(1'b1);

    // Reset with results pending: nothing may emerge afterwards.
    ready_mode = 1;
    for (int k = 1; k <= 10; k++) send(k, 0);
    do_reset(3);
    ready_mode = 0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_quiet", bus.out_valid, 0);
    end

    // Randomised frames, coefficients and backpressure.
    for (int f = 0; f < 10; f++) begin
      ready_mode = 0;
      for (int i = 0; i < TAPS; i++) begin
        if ($urandom_range(0, 4) == 0) r16 = 16'($urandom);
        else r16 = 16'($signed($urandom_range(0, 200)) - 100);
        write_coef(i, longint'(r16), 1'b0);
      end
      ready_mode = 2;
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) r16 = 16'($urandom);
        else r16 = 16'($signed($urandom_range(0, 2000)) - 1000);
        send(longint'(r16), k == len - 1);
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
      wait_drained(1'b1);
    end

    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
